// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared types and default geometry for the direct-mapped
//               instruction cache: word type, frame layout, index/tag widths
//               and the fill state machine encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    // Default geometry; the cache module takes these as parameter defaults.
    localparam int ICACHE_NSETS  = 16;
    localparam int ICACHE_WORD_W = 32;
    localparam int ICACHE_CNT_W  = 32;
    localparam int ICACHE_IDX_W  = $clog2(ICACHE_NSETS);
    localparam int ICACHE_TAG_W  = ICACHE_WORD_W - ICACHE_IDX_W - 2;

    typedef logic [ICACHE_WORD_W-1:0] word_t;

    // One cache frame at the default geometry.
    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage : icache_pkg
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module      : icache
// Description : Direct-mapped, read-only instruction cache sitting between
//               the fetch stage and the memory controller. Hits are returned
//               combinationally; a miss issues one single-word read and
//               fills the indexed frame. Hit/miss counters are kept for
//               performance reporting.
// Ports       : CLK, nRST        - clock, asynchronous active-low reset
//               imemREN/imemaddr - fetch request and byte address
//               ihit/imemload    - instruction valid / instruction word
//               iREN/iaddr       - fill read request / word-aligned address
//               iwait/iload      - memory busy / fill data
//               hit_count        - cycles with ihit=1 (wraps)
//               miss_count       - misses started (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module icache
    import icache_pkg::*;
#(
    parameter int NSETS  = ICACHE_NSETS,
    parameter int WORD_W = ICACHE_WORD_W,
    parameter int CNT_W  = ICACHE_CNT_W
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [WORD_W-1:0] iload,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int IDX_W = $clog2(NSETS);
    localparam int TAG_W = WORD_W - IDX_W - 2;
    localparam logic [WORD_W-1:0] ALIGN_MASK = {{(WORD_W-2){1'b1}}, 2'b00};

    icache_state_t state;
    icache_state_t state_next;

    // Valid bits are reset; tag and data arrays are not.
    logic [NSETS-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [NSETS];
    logic [WORD_W-1:0] data_mem [NSETS];

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic [WORD_W-1:0] fill_addr;
    logic              lookup_hit;
    logic              start_fill;
    logic              fill_done;

    assign req_idx   = imemaddr[IDX_W+1:2];
    assign req_tag   = imemaddr[WORD_W-1:IDX_W+2];
    // The latched fill address in iaddr is the only record of which frame
    // is being filled, so the fetch address may change freely during FILL.
    assign fill_idx  = iaddr[IDX_W+1:2];
    assign fill_tag  = iaddr[WORD_W-1:IDX_W+2];
    assign fill_addr = imemaddr & ALIGN_MASK;

    assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);

    // ------------------------------------------------------------------
    // State, fill address, valid bits and counters
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            iaddr      <= '0;
            valid      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_next;
            if (start_fill) begin
                iaddr      <= fill_addr;
                miss_count <= miss_count + CNT_W'(1);
            end
            if (fill_done) begin
                valid[fill_idx] <= 1'b1;
            end
            if (ihit) begin
                hit_count <= hit_count + CNT_W'(1);
            end
        end
    end

    // Frame payload; written only when a fill completes.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= iload;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        start_fill = 1'b0;
        fill_done  = 1'b0;

        case (state)
            IDLE: begin
                if (imemREN) begin
                    if (lookup_hit) begin
                        ihit     = 1'b1;
                        imemload = data_mem[req_idx];
                    end else begin
                        start_fill = 1'b1;
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                // ihit stays low even on the completion cycle; the hit is
                // observed from IDLE on the following cycle.
                iREN = 1'b1;
                if (!iwait) begin
                    fill_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule : icache
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache
// Description : Self-checking bench for icache. A behavioural memory model
//               answers fills after a fixed number of busy cycles; expected
//               instruction words are queued when a fetch is issued and
//               popped by a monitor whenever the cache reports a hit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache;

    localparam int TIMEOUT = 60;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int tests;
    int fails;
    int mem_lat;
    int wcnt;

    logic [31:0] sb_q [$];

    icache #(
        .NSETS (16),
        .WORD_W(32),
        .CNT_W (32)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .ihit      (ihit),
        .imemload  (imemload),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w == 32'h0000_0040) return 32'h2401_0005;
        return {w[15:0] ^ 16'hA5A5, w[15:0]};
    endfunction

    // Memory: busy for mem_lat cycles of each request, then one ready cycle.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST)            wcnt <= 0;
        else if (!iREN)       wcnt <= 0;
        else if (wcnt == mem_lat) wcnt <= 0;
        else                  wcnt <= wcnt + 1;
    end
    assign iwait = !(iREN && (wcnt == mem_lat));
    assign iload = (iREN && !iwait) ? mem_word(iaddr) : 32'hDEAD_BEEF;

    // Scoreboard monitor: every hit must match the oldest queued word.
    always @(negedge CLK) begin
        if (nRST && ihit) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_hit: ihit=1 addr=%h data=%h, required no hit",
                         imemaddr, imemload);
            end else begin
                logic [31:0] exp;
                exp = sb_q.pop_front();
                if (imemload !== exp) begin
                    fails++;
                    $display("FAIL sb_imemload: addr=%h got %h, required %h",
                             imemaddr, imemload, exp);
                end
            end
        end
    end

    // Issue a fetch and hold it until the hit; returns cycles with iREN=1.
    // Entered and left at #1 after a rising edge.
    task automatic do_fetch(input logic [31:0] addr, output int ren, output bit timed_out);
        int cyc;
        sb_q.push_back(mem_word(addr));
        imemaddr = addr;
        imemREN  = 1'b1;
        ren = 0;
        cyc = 0;
        @(negedge CLK);
        while (!ihit && cyc < TIMEOUT) begin
            if (iREN) ren++;
            cyc++;
            @(negedge CLK);
        end
        timed_out = !ihit;
        @(posedge CLK); #1;
        imemREN = 1'b0;
    endtask

    task automatic test_reset;
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = '0;
        repeat (3) @(posedge CLK);
        #1;
        tests++;
        if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'h0 || imemload !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: ihit=%b iREN=%b iaddr=%h imemload=%h, required 0 0 0 0",
                     ihit, iREN, iaddr, imemload);
        end
        tests++;
        if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
            fails++;
            $display("FAIL reset_counters: hit=%0d miss=%0d, required 0 0", hit_count, miss_count);
        end
        nRST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_cold_miss;
        int ren;
        bit to;
        do_fetch(32'h0000_0040, ren, to);
        tests++;
        if (to || ren != 4) begin
            fails++;
            $display("FAIL cold_miss_latency: iREN cycles=%0d timeout=%0b, required 4 0", ren, to);
        end
        tests++;
        if (miss_count !== 32'd1) begin
            fails++;
            $display("FAIL cold_miss_count: got %0d, required 1", miss_count);
        end
        tests++;
        if (hit_count !== 32'd1) begin
            fails++;
            $display("FAIL cold_hit_count: got %0d, required 1", hit_count);
        end
    endtask

    task automatic test_fill_addr;
        int  cyc;
        int  bad;
        imemaddr = 32'h0000_0040;
        // 0x40 is cached: must hit without a memory read.
        sb_q.push_back(mem_word(32'h40));
        imemREN = 1'b1;
        @(negedge CLK);
        tests++;
        if (ihit !== 1'b1 || iREN !== 1'b0) begin
            fails++;
            $display("FAIL rehit_0x40: ihit=%b iREN=%b, required 1 0", ihit, iREN);
        end
        @(posedge CLK); #1;
        // Miss on 0x0000_00C8: iaddr must carry the aligned address throughout.
        imemaddr = 32'h0000_00CA;
        sb_q.push_back(mem_word(32'hC8));
        cyc = 0;
        bad = 0;
        @(negedge CLK);
        while (!ihit && cyc < TIMEOUT) begin
            if (iREN && iaddr !== 32'h0000_00C8) bad++;
            cyc++;
            @(negedge CLK);
        end
        tests++;
        if (bad != 0 || !ihit) begin
            fails++;
            $display("FAIL fill_iaddr: bad cycles=%0d iaddr=%h ihit=%b, required 0 000000c8 1",
                     bad, iaddr, ihit);
        end
        @(posedge CLK); #1;
        imemREN = 1'b0;
    endtask

    task automatic test_conflict;
        int ren;
        bit to;
        logic [31:0] m0;
        m0 = miss_count;
        do_fetch(32'h0000_0080, ren, to);
        tests++;
        if (to || ren != 4) begin
            fails++;
            $display("FAIL conflict_0x80: iREN cycles=%0d timeout=%0b, required 4 0", ren, to);
        end
        do_fetch(32'h0000_0040, ren, to);
        tests++;
        if (to || ren != 4) begin
            fails++;
            $display("FAIL conflict_0x40: iREN cycles=%0d timeout=%0b, required 4 0", ren, to);
        end
        tests++;
        if (miss_count !== m0 + 32'd2) begin
            fails++;
            $display("FAIL conflict_miss_count: got %0d, required %0d", miss_count, m0 + 32'd2);
        end
    endtask

    task automatic test_flush_mid_fill;
        int cyc;
        int ren44;
        int ren100;
        int ren;
        bit to;
        logic [31:0] m0;
        m0 = miss_count;
        imemaddr = 32'h0000_0044;
        imemREN  = 1'b1;
        @(posedge CLK); #1;
        // Fill for 0x44 is outstanding; redirect fetch as a branch would.
        imemaddr = 32'h0000_0100;
        sb_q.push_back(mem_word(32'h100));
        ren44  = 0;
        ren100 = 0;
        cyc    = 0;
        @(negedge CLK);
        while (!ihit && cyc < TIMEOUT) begin
            if (iREN && iaddr == 32'h0000_0044) ren44++;
            if (iREN && iaddr == 32'h0000_0100) ren100++;
            cyc++;
            @(negedge CLK);
        end
        tests++;
        if (ren44 != 4 || ren100 != 4 || !ihit) begin
            fails++;
            $display("FAIL flush_fills: 0x44 cycles=%0d 0x100 cycles=%0d ihit=%b, required 4 4 1",
                     ren44, ren100, ihit);
        end
        @(posedge CLK); #1;
        imemREN = 1'b0;
        tests++;
        if (miss_count !== m0 + 32'd2) begin
            fails++;
            $display("FAIL flush_miss_count: got %0d, required %0d", miss_count, m0 + 32'd2);
        end
        do_fetch(32'h0000_0044, ren, to);
        tests++;
        if (to || ren != 0) begin
            fails++;
            $display("FAIL flush_0x44_hit: iREN cycles=%0d timeout=%0b, required 0 0", ren, to);
        end
    endtask

    task automatic test_idle_unaligned;
        int ren_seen;
        int ren;
        bit to;
        logic [31:0] h0;
        logic [31:0] m0;
        h0 = hit_count;
        m0 = miss_count;
        imemREN  = 1'b0;
        imemaddr = 32'h0000_0300;
        ren_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (iREN) ren_seen++;
        end
        @(posedge CLK); #1;
        tests++;
        if (ren_seen != 0 || hit_count !== h0 || miss_count !== m0) begin
            fails++;
            $display("FAIL idle: iREN cycles=%0d hit=%0d miss=%0d, required 0 %0d %0d",
                     ren_seen, hit_count, miss_count, h0, m0);
        end
        // Index 0 now belongs to 0x100, so 0x40 refills first.
        do_fetch(32'h0000_0040, ren, to);
        do_fetch(32'h0000_0043, ren, to);
        tests++;
        if (to || ren != 0) begin
            fails++;
            $display("FAIL unaligned_0x43: iREN cycles=%0d timeout=%0b, required 0 0", ren, to);
        end
    endtask

    task automatic test_back_to_back;
        int ren;
        bit to;
        int nhit;
        logic [31:0] h0;
        logic [31:0] m0;
        m0 = miss_count;
        for (int i = 0; i < 16; i++) begin
            do_fetch(32'(i * 4), ren, to);
        end
        tests++;
        if (miss_count !== m0 + 32'd16) begin
            fails++;
            $display("FAIL b2b_fill_misses: got %0d, required %0d", miss_count, m0 + 32'd16);
        end
        h0 = hit_count;
        m0 = miss_count;
        nhit = 0;
        imemREN = 1'b1;
        for (int i = 0; i < 16; i++) begin
            imemaddr = 32'(i * 4);
            sb_q.push_back(mem_word(32'(i * 4)));
            @(negedge CLK);
            if (ihit) nhit++;
            @(posedge CLK); #1;
        end
        imemREN = 1'b0;
        tests++;
        if (nhit != 16) begin
            fails++;
            $display("FAIL b2b_hits: got %0d hit cycles, required 16", nhit);
        end
        tests++;
        if (hit_count !== h0 + 32'd16 || miss_count !== m0) begin
            fails++;
            $display("FAIL b2b_counters: hit=%0d miss=%0d, required %0d %0d",
                     hit_count, miss_count, h0 + 32'd16, m0);
        end
    endtask

    task automatic test_reset_midrun;
        int ren;
        bit to;
        imemaddr = 32'h0000_0200;
        imemREN  = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        tests++;
        if (iREN !== 1'b1) begin
            fails++;
            $display("FAIL midrun_in_fill: iREN=%b, required 1", iREN);
        end
        nRST    = 1'b0;
        imemREN = 1'b0;
        #1;
        tests++;
        if (ihit !== 1'b0 || iREN !== 1'b0 || hit_count !== 32'h0 || miss_count !== 32'h0) begin
            fails++;
            $display("FAIL midrun_async_reset: ihit=%b iREN=%b hit=%0d miss=%0d, required 0 0 0 0",
                     ihit, iREN, hit_count, miss_count);
        end
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
        do_fetch(32'h0000_0040, ren, to);
        tests++;
        if (to || ren != 4 || miss_count !== 32'd1) begin
            fails++;
            $display("FAIL post_reset_miss: iREN cycles=%0d miss=%0d timeout=%0b, required 4 1 0",
                     ren, miss_count, to);
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        mem_lat = 3;
        nRST    = 1'b0;
        imemREN = 1'b0;
        imemaddr = '0;
        test_reset();
        test_cold_miss();
        test_fill_addr();
        test_conflict();
        test_flush_mid_fill();
        test_idle_unaligned();
        test_back_to_back();
        test_reset_midrun();
        repeat (2) @(posedge CLK);
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: %0d expected hits never seen, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_icache
`default_nettype wire

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage and the memory controller.
- Produces `ihit`/`imemload` for fetch. `ihit` gates the PC and IF/ID advance alongside the hazard unit's stall/flush outputs.
- On a miss, issues a single-word read to the memory controller and fills the frame.
- Keeps hit/miss counters for performance reporting.

Parameters:
- NSETS, 16, number of frames (power of 2, ≥2).
- WORD_W, 32, address and data width.
- CNT_W, 32, width of the hit and miss counters.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- imemREN  in  1  fetch requests an instruction this cycle.
- imemaddr  in  WORD_W  byte address of the instruction (word-aligned).
- ihit  out  1  instruction valid on imemload this cycle.
- imemload  out  WORD_W  instruction word.
- iREN  out  1  read request to the memory controller.
- iaddr  out  WORD_W  word-aligned address of the fill.
- iwait  in  1  memory controller busy; fill data is not yet valid.
- iload  in  WORD_W  fill data, valid when iREN=1 and iwait=0.
- hit_count  out  CNT_W  number of hit cycles.
- miss_count  out  CNT_W  number of misses started.

Behaviour:
- Reset is asynchronous on nRST low:
  - all valid bits cleared;
  - state=IDLE, counters=0;
  - ihit=0, iREN=0, iaddr=0, imemload=0.
- Tag and data arrays are not reset.
- Address split, with IDX_W = log2(NSETS):
  - [1:0] ignored;
  - index = [IDX_W+1:2];
  - tag = [WORD_W-1:IDX_W+2].
- Frame: valid (1), tag, data (WORD_W).
- Hit rule (combinational, zero latency):
  - ihit = imemREN && state==IDLE && valid[idx] && tag[idx]==req_tag;
  - imemload = data[idx] when ihit=1, else 0.
- States are IDLE and FILL.
- IDLE:
  - imemREN && !hit → latch fill address (imemaddr with [1:0] forced to 0) into iaddr; go to FILL.
  - miss_count increments on that edge.
  - imemREN=0 → stay in IDLE; outputs idle.
- FILL:
  - iREN=1, iaddr holds the latched address.
  - Each cycle with iwait=0 → write data=iload, tag and valid=1 at the latched index; go to IDLE.
  - ihit is forced to 0 throughout FILL, including the completion cycle.
  - The hit is therefore seen one cycle after completion: total miss latency = memory latency + 1.
  - iwait=1 → stay in FILL indefinitely.
- Fills are never aborted. Deasserting imemREN or changing imemaddr during FILL (e.g. a branch/jump flush) does not cancel the outstanding read.
  - The fill completes into the latched frame.
  - IDLE then re-evaluates the current imemaddr.
- iREN is low in IDLE. At most one fill is outstanding.
- Conflict miss: a new tag on a valid index overwrites the frame; no replacement state.
- hit_count increments on every cycle with ihit=1.
- Both counters wrap modulo 2^CNT_W.
- Reset asserted mid-FILL returns the block to IDLE immediately with iREN=0. The partial fill is discarded and no valid bit is set.

Decomposition:
- Shared cache package holds:
  - word_t;
  - icache frame struct (valid, tag, data);
  - index/tag width constants derived from NSETS;
  - state enum {IDLE, FILL}.
- No sub-module; the arrays and FSM live in a single always_ff / always_comb pair.

Test Plan:
- Reset:
  - assert nRST=0 mid-run → ihit=0, iREN=0, hit_count=0, miss_count=0 asynchronously;
  - first fetch of 0x0000_0040 afterwards misses.
- Cold miss then hit:
  - fetch 0x0000_0040 with memory iwait=1 for 3 cycles, iload=0x2401_0005;
  - iREN=1 with iaddr=0x40 for 4 cycles;
  - next cycle ihit=1, imemload=0x2401_0005, miss_count=1;
  - following cycle hit_count=1.
- Conflict:
  - after the fill above, fetch 0x0000_0080 (same index 0, different tag) → miss and fill;
  - refetch 0x40 → miss again; miss_count=3.
- Flush mid-fill:
  - miss on 0x44 and, while iwait=1, change imemaddr to 0x100;
  - fill completes to 0x44's frame;
  - IDLE then starts a fill for 0x100;
  - later fetch of 0x44 hits with no iREN.
- Unaligned/idle:
  - imemREN=0 for 10 cycles → iREN=0, counters unchanged;
  - fetch 0x43 after 0x40 is cached → hit.
- Back-to-back hits: 16 sequential addresses 0x0–0x3C, each filled once, then replayed → 16 consecutive ihit cycles, hit_count +16, miss_count unchanged.
